// File: rtl/adc_seq_pkg.sv
// adc_seq_pkg: shared state type and elaboration helpers for the ADC sample sequencer
package adc_seq_pkg;

  typedef enum logic [2:0] {IDLE, SETTLE, START, WAIT, NEXT} state_t;

  function automatic int tick_div(input int clk_hz, input int sample_hz);
    return clk_hz / sample_hz;
  endfunction

  // lowest set bit of mask strictly above idx and below n; n when there is none
  function automatic int next_bit(input logic [15:0] mask, input int idx, input int n);
    int r;
    r = n;
    for (int k = 15; k >= 0; k--)
      if (k > idx && k < n && mask[k[3:0]]) r = k;
    return r;
  endfunction

endpackage

// File: rtl/adc_sample_sequencer_if.sv
// adc_sample_sequencer_if: channel-tagged sample stream toward the filter chain
interface adc_sample_sequencer_if #(
  parameter int WIDTH = 12,
  parameter int CHW   = 2
);
  logic [WIDTH-1:0] sample;
  logic [CHW-1:0]   sample_ch;
  logic             sample_valid;
  logic             sample_ready;

  modport master (output sample, sample_ch, sample_valid, input sample_ready);
  modport slave  (input sample, sample_ch, sample_valid, output sample_ready);
endinterface

// File: rtl/adc_rate_tick.sv
// adc_rate_tick: enable-gated divider producing a one-cycle tick every DIV cycles
module adc_rate_tick #(
  parameter int DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic en_i,
  output logic tick_o
);
  localparam int CW = $clog2(DIV);

  logic [CW-1:0] r_cnt;
  logic          r_tick;
  logic          w_wrap;

  assign w_wrap = r_cnt == CW'(DIV - 1);
  assign tick_o = r_tick;

  // count while enabled, restart from zero whenever enable drops
  always_ff @(posedge clk) begin
    if (rst || !en_i) begin
      r_cnt  <= '0;
      r_tick <= 1'b0;
    end else begin
      r_cnt  <= w_wrap ? '0 : r_cnt + 1'b1;
      r_tick <= w_wrap;
    end
  end
endmodule

// File: rtl/adc_sample_sequencer.sv
// adc_sample_sequencer: frame-paced mux walker that starts ADC conversions and streams tagged samples
module adc_sample_sequencer
  import adc_seq_pkg::*;
#(
  parameter int CLK_HZ      = 50_000_000,
  parameter int SAMPLE_HZ   = 1_000,
  parameter int NUM_CH      = 4,
  parameter int WIDTH       = 12,
  parameter int SETTLE_CYC  = 16,
  parameter int TIMEOUT_CYC = 8192
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      enable_i,
  input  logic [NUM_CH-1:0]         ch_mask_i,
  output logic                      adc_start_o,
  output logic [$clog2(NUM_CH)-1:0] adc_ch_o,
  input  logic [WIDTH-1:0]          adc_data_i,
  input  logic                      adc_valid_i,
  adc_sample_sequencer_if.master    s_if,
  output logic                      frame_done_o,
  output logic                      timeout_o,
  output logic                      overrun_o,
  output logic                      missed_tick_o,
  output logic                      busy_o
);
  localparam int CHW      = $clog2(NUM_CH);
  localparam int TICK_DIV = tick_div(CLK_HZ, SAMPLE_HZ);
  localparam int SW       = $clog2(SETTLE_CYC + 1);
  localparam int TW       = $clog2(TIMEOUT_CYC);

  if (TICK_DIV < 2 || NUM_CH < 2 || NUM_CH > 16) begin : g_bad_param
    $error("adc_sample_sequencer: TICK_DIV must be >= 2 and NUM_CH in 2..16");
  end

  state_t            r_state, w_state;
  logic [SW-1:0]     r_set_cnt, w_set_cnt;
  logic [TW-1:0]     r_to_cnt, w_to_cnt;
  logic [NUM_CH-1:0] r_mask, w_mask;
  logic [CHW-1:0]    r_ch, w_ch;
  logic              w_tick, w_fd, w_to, w_cap;
  logic              r_start, r_fd, r_to, r_ovr, r_miss, r_busy;
  logic [WIDTH-1:0]  r_sample;
  logic [CHW-1:0]    r_sch;
  logic              r_sval;
  int                w_first, w_nb;

  adc_rate_tick #(.DIV(TICK_DIV)) u_tick (
    .clk    (clk),
    .rst    (rst),
    .en_i   (enable_i),
    .tick_o (w_tick)
  );

  assign w_first = next_bit(16'(ch_mask_i), -1, NUM_CH);
  assign w_nb    = next_bit(16'(r_mask), int'(r_ch), NUM_CH);

  assign adc_start_o       = r_start;
  assign adc_ch_o          = r_ch;
  assign frame_done_o      = r_fd;
  assign timeout_o         = r_to;
  assign overrun_o         = r_ovr;
  assign missed_tick_o     = r_miss;
  assign busy_o            = r_busy;
  assign s_if.sample       = r_sample;
  assign s_if.sample_ch    = r_sch;
  assign s_if.sample_valid = r_sval;

  // next state, counters, channel select and one-cycle event strobes
  always_comb begin
    w_state   = r_state;
    w_set_cnt = r_set_cnt;
    w_to_cnt  = r_to_cnt;
    w_mask    = r_mask;
    w_ch      = r_ch;
    w_fd      = 1'b0;
    w_to      = 1'b0;
    w_cap     = 1'b0;
    unique case (r_state)
      IDLE:
        if (w_tick && enable_i && |ch_mask_i) begin
          w_state   = SETTLE;
          w_mask    = ch_mask_i;
          w_ch      = CHW'(w_first);
          w_set_cnt = '0;
        end
      SETTLE:
        if (r_set_cnt == SW'(SETTLE_CYC - 1)) w_state = START;
        else w_set_cnt = r_set_cnt + 1'b1;
      START: begin
        w_state  = WAIT;
        w_to_cnt = '0;
      end
      WAIT:
        if (adc_valid_i) begin
          w_cap   = 1'b1;
          w_state = NEXT;
        end else if (r_to_cnt == TW'(TIMEOUT_CYC - 1)) begin
          w_to    = 1'b1;
          w_state = NEXT;
        end else w_to_cnt = r_to_cnt + 1'b1;
      NEXT:
        if (enable_i && w_nb < NUM_CH) begin
          w_state   = SETTLE;
          w_ch      = CHW'(w_nb);
          w_set_cnt = '0;
        end else begin
          w_state = IDLE;
          w_fd    = enable_i;
        end
      default: w_state = IDLE;
    endcase
  end

  // sequencer state and registered control outputs; missed ticks are sticky
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_set_cnt <= '0;
      r_to_cnt  <= '0;
      r_mask    <= '0;
      r_ch      <= '0;
      r_start   <= 1'b0;
      r_fd      <= 1'b0;
      r_to      <= 1'b0;
      r_miss    <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_state   <= w_state;
      r_set_cnt <= w_set_cnt;
      r_to_cnt  <= w_to_cnt;
      r_mask    <= w_mask;
      r_ch      <= w_ch;
      r_start   <= w_state == START;
      r_fd      <= w_fd;
      r_to      <= w_to;
      r_busy    <= w_state != IDLE;
      if (w_tick && r_state != IDLE) r_miss <= 1'b1;
    end
  end

  // single-entry output register: a capture into a stalled full entry is dropped and flagged
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sample <= '0;
      r_sch    <= '0;
      r_sval   <= 1'b0;
      r_ovr    <= 1'b0;
    end else if (w_cap && !(r_sval && !s_if.sample_ready)) begin
      r_sample <= adc_data_i;
      r_sch    <= r_ch;
      r_sval   <= 1'b1;
    end else if (w_cap) begin
      r_ovr <= 1'b1;
    end else if (r_sval && s_if.sample_ready) begin
      r_sval <= 1'b0;
    end
  end
endmodule

// File: tb/tb_adc_sample_sequencer.sv
// tb_adc_sample_sequencer: directed checks of frame timing, timeout, overrun, missed tick and reset
module tb_adc_sample_sequencer;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable_i = 1'b0;
  logic [3:0]  ch_mask_i = 4'd0;
  logic        adc_start_o, adc_valid_i;
  logic [1:0]  adc_ch_o;
  logic [11:0] adc_data_i;
  logic        frame_done_o, timeout_o, overrun_o, missed_tick_o, busy_o;

  int n_chk = 0, n_fail = 0;
  int cyc = 0, c0 = 0;
  int lat = 30, dead_ch = -1;
  int n_fd = 0, n_to = 0, fd_t = 0, to_t = 0;
  bit busy_seen = 1'b0;
  int st_ch[$], st_t[$], acc_v[$], acc_t[$];

  adc_sample_sequencer_if #(.WIDTH(12), .CHW(2)) s_if ();

  adc_sample_sequencer #(
    .CLK_HZ(1000), .SAMPLE_HZ(10), .NUM_CH(4), .WIDTH(12), .SETTLE_CYC(4), .TIMEOUT_CYC(64)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .enable_i      (enable_i),
    .ch_mask_i     (ch_mask_i),
    .adc_start_o   (adc_start_o),
    .adc_ch_o      (adc_ch_o),
    .adc_data_i    (adc_data_i),
    .adc_valid_i   (adc_valid_i),
    .s_if          (s_if),
    .frame_done_o  (frame_done_o),
    .timeout_o     (timeout_o),
    .overrun_o     (overrun_o),
    .missed_tick_o (missed_tick_o),
    .busy_o        (busy_o)
  );

  initial forever #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // event log sampled mid-cycle
  always @(negedge clk) begin
    if (adc_start_o) begin
      st_ch.push_back(int'(adc_ch_o));
      st_t.push_back(cyc);
    end
    if (frame_done_o) begin
      n_fd++;
      fd_t = cyc;
    end
    if (timeout_o) begin
      n_to++;
      to_t = cyc;
    end
    if (busy_o) busy_seen = 1'b1;
    if (s_if.sample_valid && s_if.sample_ready) begin
      acc_v.push_back(int'({s_if.sample_ch, s_if.sample}));
      acc_t.push_back(cyc);
    end
  end

  // ADC model: result 'lat' cycles after the start cycle, silent on dead_ch
  initial begin
    logic [1:0] ch;
    adc_valid_i = 1'b0;
    adc_data_i  = '0;
    forever begin
      @(posedge clk);
      #1;
      if (adc_start_o && int'(adc_ch_o) != dead_ch) begin
        ch = adc_ch_o;
        repeat (lat) @(posedge clk);
        #1;
        adc_data_i  = 12'h5A0 | 12'(ch);
        adc_valid_i = 1'b1;
        @(posedge clk);
        #1;
        adc_valid_i = 1'b0;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_rst();
    enable_i = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    st_ch.delete(); st_t.delete(); acc_v.delete(); acc_t.delete();
    n_fd = 0; n_to = 0; busy_seen = 1'b0;
    rst = 1'b0;
  endtask

  task automatic go(input logic [3:0] mask);
    ch_mask_i = mask;
    enable_i  = 1'b1;
    c0 = cyc;
  endtask

  initial begin
    s_if.sample_ready = 1'b1;
    do_rst();
    check("reset_outs", 32'({adc_start_o, adc_ch_o, s_if.sample, s_if.sample_ch, s_if.sample_valid,
                             frame_done_o, timeout_o, overrun_o, missed_tick_o, busy_o}), 32'd0);

    // two frames, mask 0101, ADC latency 30, tick every 100 cycles
    go(4'b0101);
    repeat (290) @(negedge clk);
    check("f_nstart", 32'(st_ch.size()), 32'd4);
    check("f_chseq", 32'({st_ch[0][1:0], st_ch[1][1:0], st_ch[2][1:0], st_ch[3][1:0]}), 32'b00100010);
    check("f_tick2start", 32'(st_t[0] - c0), 32'd105);
    check("f_ch_spacing", 32'(st_t[1] - st_t[0]), 32'd36);
    check("f_frame_period", 32'(st_t[2] - st_t[0]), 32'd100);
    check("f_nsample", 32'(acc_v.size()), 32'd4);
    check("f_samples", 32'({acc_v[0][13:0], acc_v[1][13:0]}), 32'({14'h05A0, 14'h25A2}));
    check("f_sample_lat", 32'(acc_t[0] - st_t[0]), 32'd31);
    check("f_nframe_done", 32'(n_fd), 32'd2);
    check("f_fd_lat", 32'(fd_t - st_t[3]), 32'd32);
    check("f_flags", 32'({overrun_o, missed_tick_o, timeout_o, busy_o}), 32'd0);

    // zero mask: ticks ignored
    do_rst();
    go(4'b0000);
    repeat (320) @(negedge clk);
    check("z_nstart", 32'(st_ch.size()), 32'd0);
    check("z_busy_seen", 32'(busy_seen), 32'd0);

    // ch1 never answers: timeout then ch2
    do_rst();
    dead_ch = 1;
    go(4'b0111);
    repeat (290) @(negedge clk);
    check("t_chseq", 32'(st_ch.size() == 3 && st_ch[0] == 0 && st_ch[1] == 1 && st_ch[2] == 2), 32'd1);
    check("t_to_lat", 32'(to_t - st_t[1]), 32'd65);
    check("t_nto", 32'(n_to), 32'd1);
    check("t_next_start", 32'(st_t[2] - to_t), 32'd5);
    check("t_samples", 32'(acc_v.size() == 2 && acc_v[0] == 'h05A0 && acc_v[1] == 'h25A2), 32'd1);
    check("t_nframe_done", 32'(n_fd), 32'd1);
    check("t_missed", 32'(missed_tick_o), 32'd1);
    dead_ch = -1;

    // downstream stalled across two captures
    do_rst();
    s_if.sample_ready = 1'b0;
    go(4'b0101);
    repeat (190) @(negedge clk);
    enable_i = 1'b0;
    check("o_held", 32'({s_if.sample_valid, s_if.sample_ch, s_if.sample}), 32'({1'b1, 2'd0, 12'h5A0}));
    check("o_overrun", 32'(overrun_o), 32'd1);
    check("o_nacc", 32'(acc_v.size()), 32'd0);
    s_if.sample_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("o_drain", 32'(acc_v.size() == 1 && acc_v[0] == 'h05A0), 32'd1);
    check("o_valid_low", 32'(s_if.sample_valid), 32'd0);
    check("o_sticky", 32'(overrun_o), 32'd1);
    do_rst();
    check("o_cleared", 32'(overrun_o), 32'd0);

    // slow ADC overlaps the next tick, then enable drops mid-WAIT of the next frame
    lat = 50;
    go(4'b0101);
    repeat (320) @(negedge clk);
    enable_i = 1'b0;
    repeat (45) @(negedge clk);
    check("m_missed", 32'(missed_tick_o), 32'd1);
    check("m_chseq", 32'(st_ch.size() == 3 && st_ch[0] == 0 && st_ch[1] == 2 && st_ch[2] == 0), 32'd1);
    check("m_second_start", 32'(st_t[2] - c0), 32'd305);
    check("m_samples", 32'(acc_v.size() == 3 && acc_v[2] == 'h05A0), 32'd1);
    check("m_nframe_done", 32'(n_fd), 32'd1);
    check("m_idle", 32'(busy_o), 32'd0);
    lat = 30;

    // reset while settling on ch2
    do_rst();
    go(4'b0100);
    repeat (102) @(negedge clk);
    check("r_settling", 32'({busy_o, adc_ch_o}), 32'({1'b1, 2'd2}));
    rst = 1'b1;
    @(negedge clk);
    check("r_outs", 32'({adc_start_o, adc_ch_o, s_if.sample, s_if.sample_ch, s_if.sample_valid,
                         frame_done_o, timeout_o, overrun_o, missed_tick_o, busy_o}), 32'd0);
    rst = 1'b0;
    repeat (47) @(negedge clk);
    check("r_no_start", 32'(st_ch.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
